// File: rtl/riscv_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and a size helper.
// Pure declarations, no logic.
package riscv_pkg;

    typedef enum logic [2:0] {
        MS_B  = 3'b000,
        MS_H  = 3'b001,
        MS_W  = 3'b010,
        MS_D  = 3'b011,
        MS_BU = 3'b100,
        MS_HU = 3'b101,
        MS_WU = 3'b110
    } memsize_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_DONE
    } lsu_state_t;

    // Zero flags the unused funct3 encoding so the caller can reject it.
    function automatic logic [3:0] size_bytes(memsize_t s);
        case (s)
            MS_B, MS_BU: size_bytes = 4'd1;
            MS_H, MS_HU: size_bytes = 4'd2;
            MS_W, MS_WU: size_bytes = 4'd4;
            MS_D:        size_bytes = 4'd8;
            default:     size_bytes = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Lane steering: extracts and extends load data, shifts store data and builds byte enables.
// Purely combinational.
module riscv_lsu_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int OW  = $clog2(XLEN/8),
    localparam int BW  = XLEN/8
) (
    input  logic [2:0]      size_i,
    input  logic [OW-1:0]   off_i,
    input  logic [XLEN-1:0] rdata_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] ld_data_o,
    output logic [XLEN-1:0] st_data_o,
    output logic [BW-1:0]   st_be_o
);

    logic [XLEN-1:0] shifted;
    logic [7:0]      mask;

    always_comb begin
        shifted   = rdata_i >> {off_i, 3'b000};
        ld_data_o = shifted;
        mask      = 8'h00;
        case (memsize_t'(size_i))
            MS_B:  begin ld_data_o = XLEN'($signed(shifted[7:0]));  mask = 8'h01; end
            MS_H:  begin ld_data_o = XLEN'($signed(shifted[15:0])); mask = 8'h03; end
            MS_W:  begin ld_data_o = XLEN'($signed(shifted[31:0])); mask = 8'h0F; end
            MS_BU: begin ld_data_o = XLEN'(shifted[7:0]);           mask = 8'h01; end
            MS_HU: begin ld_data_o = XLEN'(shifted[15:0]);          mask = 8'h03; end
            MS_WU: begin ld_data_o = XLEN'(shifted[31:0]);          mask = 8'h0F; end
            MS_D:  begin ld_data_o = shifted;                       mask = 8'hFF; end
            default: ;
        endcase
        st_be_o   = BW'(mask) << off_i;
        st_data_o = wdata_i << {off_i, 3'b000};
    end

endmodule

// File: rtl/riscv_lsu.sv
// M-stage load/store unit on a req/gnt/rvalid bus with stall, misalignment trap and timeout.
// Stores take 2 stall cycles, loads 3, at minimum; stallM holds the pipeline while pending.
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reqM,
    input  logic              memwriteM,
    input  logic [2:0]        memsizeM,
    input  logic [XLEN-1:0]   aluoutM,
    input  logic [XLEN-1:0]   writedataM,
    output logic              stallM,
    output logic [XLEN-1:0]   readdataM,
    output logic              doneM,
    output logic              misalignM,
    output logic              errM,
    output logic              bus_req,
    output logic              bus_we,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN/8-1:0] bus_be,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata
);

    localparam int          OW      = $clog2(XLEN/8);
    localparam int          BW      = XLEN/8;
    localparam bit          TO_EN   = (TIMEOUT > 0);
    localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    lsu_state_t      state_q;
    logic [31:0]     cnt_q;
    logic            bus_req_q, bus_we_q, err_q;
    logic [XLEN-1:0] bus_addr_q, bus_wdata_q, rdata_q;
    logic [BW-1:0]   bus_be_q;
    logic [2:0]      size_q;
    logic [OW-1:0]   off_q;

    memsize_t        size_m;
    logic [3:0]      nbytes;
    logic            misal, to_hit;
    logic [2:0]      al_size;
    logic [OW-1:0]   al_off;
    logic [XLEN-1:0] ld_data, st_data;
    logic [BW-1:0]   st_be;

    // LD, and LWU (an RV64-only load), cannot be served on a 32-bit port.
    always_comb begin
        size_m  = memsize_t'(memsizeM);
        nbytes  = size_bytes(size_m);
        misal   = (nbytes == 4'd0)
                || ((XLEN == 32) && (size_m inside {MS_D, MS_WU}))
                || ((aluoutM[2:0] & (nbytes[2:0] - 3'd1)) != 3'd0);
        al_size = (state_q == ST_IDLE) ? memsizeM : size_q;
        al_off  = (state_q == ST_IDLE) ? aluoutM[OW-1:0] : off_q;
        to_hit  = TO_EN && (cnt_q == TO_LAST);
    end

    riscv_lsu_align #(.XLEN(XLEN)) u_align (
        .size_i    (al_size),
        .off_i     (al_off),
        .rdata_i   (bus_rdata),
        .wdata_i   (writedataM),
        .ld_data_o (ld_data),
        .st_data_o (st_data),
        .st_be_o   (st_be)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            err_q       <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            rdata_q     <= '0;
            size_q      <= 3'b000;
            off_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (reqM && !misal) begin
                        state_q     <= ST_REQ;
                        cnt_q       <= '0;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= memwriteM;
                        bus_addr_q  <= {aluoutM[XLEN-1:OW], {OW{1'b0}}};
                        bus_wdata_q <= st_data;
                        bus_be_q    <= st_be;
                        size_q      <= memsizeM;
                        off_q       <= aluoutM[OW-1:0];
                    end
                end
                ST_REQ: begin
                    if (bus_gnt) begin
                        bus_req_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= bus_we_q ? ST_DONE : ST_RESP;
                    end else if (to_hit) begin
                        bus_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        rdata_q   <= '0;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_RESP: begin
                    if (bus_rvalid) begin
                        rdata_q <= ld_data;
                        state_q <= ST_DONE;
                    end else if (to_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: begin
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign stallM    = reqM && !misal && (state_q != ST_DONE);
    assign misalignM = reqM && misal && (state_q == ST_IDLE);
    assign doneM     = (state_q == ST_DONE) && !err_q;
    assign errM      = (state_q == ST_DONE) && err_q;
    assign readdataM = rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: a 32-bit instance with a short timeout and a 64-bit instance.
// Inputs change on the falling edge; outputs are sampled on the falling edge or just after a drive.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst32, rst64, req32, req64, we, gnt, rvalid, sel;
    logic [2:0]  size;
    logic [63:0] addr, wdata, rdata;

    logic        st32, dn32, ms32, er32, br32, bw32;
    logic [31:0] rd32, ba32, bwd32;
    logic [3:0]  be32;
    logic        st64, dn64, ms64, er64, br64, bw64;
    logic [63:0] rd64, ba64, bwd64;
    logic [7:0]  be64;

    logic        c_stall, c_done, c_mis, c_err, c_breq, c_bwe;
    logic [63:0] c_rd, c_baddr, c_bwd;
    logic [7:0]  c_be;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    riscv_lsu #(.XLEN(32), .TIMEOUT(4)) dut32 (
        .clk(clk), .reset(rst32), .reqM(req32), .memwriteM(we), .memsizeM(size),
        .aluoutM(addr[31:0]), .writedataM(wdata[31:0]),
        .stallM(st32), .readdataM(rd32), .doneM(dn32), .misalignM(ms32), .errM(er32),
        .bus_req(br32), .bus_we(bw32), .bus_addr(ba32), .bus_be(be32), .bus_wdata(bwd32),
        .bus_gnt(gnt), .bus_rvalid(rvalid), .bus_rdata(rdata[31:0])
    );

    riscv_lsu #(.XLEN(64), .TIMEOUT(16)) dut64 (
        .clk(clk), .reset(rst64), .reqM(req64), .memwriteM(we), .memsizeM(size),
        .aluoutM(addr), .writedataM(wdata),
        .stallM(st64), .readdataM(rd64), .doneM(dn64), .misalignM(ms64), .errM(er64),
        .bus_req(br64), .bus_we(bw64), .bus_addr(ba64), .bus_be(be64), .bus_wdata(bwd64),
        .bus_gnt(gnt), .bus_rvalid(rvalid), .bus_rdata(rdata)
    );

    assign c_stall = sel ? st64 : st32;
    assign c_done  = sel ? dn64 : dn32;
    assign c_mis   = sel ? ms64 : ms32;
    assign c_err   = sel ? er64 : er32;
    assign c_breq  = sel ? br64 : br32;
    assign c_bwe   = sel ? bw64 : bw32;
    assign c_rd    = sel ? rd64  : {32'd0, rd32};
    assign c_baddr = sel ? ba64  : {32'd0, ba32};
    assign c_bwd   = sel ? bwd64 : {32'd0, bwd32};
    assign c_be    = sel ? be64  : {4'd0, be32};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One access with gnt on the first REQ cycle and rvalid right after; called on a falling edge.
    task automatic access(input logic w, input logic [2:0] sz, input logic [63:0] a,
                          input logic [63:0] wd, input logic [63:0] rdv,
                          output int stalls, output logic [7:0] be_o, output logic [63:0] bwd_o,
                          output logic [63:0] baddr_o, output logic [63:0] rd_o, output logic done_o);
        stalls = 0;
        we = w; size = sz; addr = a; wdata = wd;
        if (sel) req64 = 1'b1; else req32 = 1'b1;
        #1 stalls += int'(c_stall);
        @(negedge clk);
        be_o = c_be; bwd_o = c_bwd; baddr_o = c_baddr;
        chk("bus_req in REQ", 64'(c_breq), 64'd1);
        stalls += int'(c_stall);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        if (!w) begin
            stalls += int'(c_stall);
            rvalid = 1'b1; rdata = rdv;
            @(negedge clk);
            rvalid = 1'b0;
        end
        done_o = c_done; rd_o = c_rd;
        stalls += int'(c_stall);
        req32 = 1'b0; req64 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st, cyc;
        logic [7:0]  be;
        logic [63:0] bwd, ba, rd;
        logic        dn, got;

        sel = 1'b0; rst32 = 1'b1; rst64 = 1'b1; req32 = 1'b0; req64 = 1'b0;
        we = 1'b0; gnt = 1'b0; rvalid = 1'b0; size = 3'b000;
        addr = '0; wdata = '0; rdata = '0;
        repeat (2) @(negedge clk);
        rst32 = 1'b0; rst64 = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst stallM", 64'(c_stall), 64'd0);
        chk("rst doneM", 64'(c_done), 64'd0);
        chk("rst misalignM", 64'(c_mis), 64'd0);
        chk("rst errM", 64'(c_err), 64'd0);
        chk("rst bus_req", 64'(c_breq), 64'd0);
        chk("rst bus_we", 64'(c_bwe), 64'd0);
        chk("rst readdataM", c_rd, 64'd0);
        chk("rst bus_be", 64'(c_be), 64'd0);
        sel = 1'b1;
        chk("rst64 bus_addr", c_baddr, 64'd0);
        chk("rst64 bus_wdata", c_bwd, 64'd0);
        sel = 1'b0;

        // XLEN=32 loads
        access(1'b0, 3'b010, 64'h100, 64'h0, 64'hDEADBEEF, st, be, bwd, ba, rd, dn);
        chk("LW stalls", 64'(st), 64'd3);
        chk("LW bus_addr", ba, 64'h100);
        chk("LW bus_be", 64'(be), 64'hF);
        chk("LW doneM", 64'(dn), 64'd1);
        chk("LW readdataM", rd, 64'hDEADBEEF);
        chk("doneM clears", 64'(c_done), 64'd0);

        access(1'b0, 3'b000, 64'h103, 64'h0, 64'h80123456, st, be, bwd, ba, rd, dn);
        chk("LB bus_be", 64'(be), 64'h8);
        chk("LB readdataM", rd, 64'hFFFFFF80);
        access(1'b0, 3'b100, 64'h103, 64'h0, 64'h80123456, st, be, bwd, ba, rd, dn);
        chk("LBU readdataM", rd, 64'h00000080);
        access(1'b0, 3'b001, 64'h102, 64'h0, 64'h80010000, st, be, bwd, ba, rd, dn);
        chk("LH readdataM", rd, 64'hFFFF8001);
        access(1'b0, 3'b101, 64'h102, 64'h0, 64'h80010000, st, be, bwd, ba, rd, dn);
        chk("LHU readdataM", rd, 64'h00008001);

        // XLEN=32 stores
        access(1'b1, 3'b001, 64'h102, 64'h1234, 64'h0, st, be, bwd, ba, rd, dn);
        chk("SH bus_be", 64'(be), 64'hC);
        chk("SH bus_wdata", bwd, 64'h12340000);
        chk("SH bus_addr", ba, 64'h100);
        chk("SH stalls", 64'(st), 64'd2);
        chk("SH doneM", 64'(dn), 64'd1);
        access(1'b1, 3'b000, 64'h101, 64'hAB, 64'h0, st, be, bwd, ba, rd, dn);
        chk("SB bus_be", 64'(be), 64'h2);
        chk("SB bus_wdata", bwd, 64'h0000AB00);

        // Misaligned accesses never reach the bus
        we = 1'b0; size = 3'b010; addr = 64'h102; req32 = 1'b1;
        #1;
        chk("LW mis misalignM", 64'(c_mis), 64'd1);
        chk("LW mis stallM", 64'(c_stall), 64'd0);
        @(negedge clk);
        chk("LW mis bus_req", 64'(c_breq), 64'd0);
        req32 = 1'b0;
        #1;
        chk("mis one cycle", 64'(c_mis), 64'd0);
        size = 3'b011; addr = 64'h100; req32 = 1'b1;
        #1;
        chk("LD on 32b misalignM", 64'(c_mis), 64'd1);
        @(negedge clk);
        chk("LD on 32b bus_req", 64'(c_breq), 64'd0);
        req32 = 1'b0;

        // Timeout with gnt held low
        size = 3'b010; addr = 64'h104; req32 = 1'b1; gnt = 1'b0;
        cyc = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (c_err) got = 1'b1;
            else if (c_breq) cyc++;
        end
        chk("timeout errM", 64'(got), 64'd1);
        chk("timeout REQ cycles", 64'(cyc), 64'd4);
        chk("timeout bus_req", 64'(c_breq), 64'd0);
        chk("timeout readdataM", c_rd, 64'd0);
        req32 = 1'b0;
        @(negedge clk);
        chk("errM one cycle", 64'(c_err), 64'd0);
        rvalid = 1'b1; rdata = 64'h11111111;
        @(negedge clk);
        rvalid = 1'b0;
        chk("stray rvalid doneM", 64'(c_done), 64'd0);
        chk("stray rvalid readdataM", c_rd, 64'd0);

        // XLEN=64
        sel = 1'b1;
        access(1'b0, 3'b110, 64'h8, 64'h0, 64'h00000000F0000000, st, be, bwd, ba, rd, dn);
        chk("LWU64 readdataM", rd, 64'h00000000F0000000);
        chk("LWU64 bus_be", 64'(be), 64'h0F);
        access(1'b0, 3'b010, 64'hC, 64'h0, 64'h8000000000000000, st, be, bwd, ba, rd, dn);
        chk("LW64 hi readdataM", rd, 64'hFFFFFFFF80000000);
        chk("LW64 hi bus_addr", ba, 64'h8);
        access(1'b0, 3'b011, 64'h10, 64'h0, 64'h0123456789ABCDEF, st, be, bwd, ba, rd, dn);
        chk("LD64 readdataM", rd, 64'h0123456789ABCDEF);
        access(1'b1, 3'b010, 64'h14, 64'hCAFEF00D, 64'h0, st, be, bwd, ba, rd, dn);
        chk("SW64 bus_be", 64'(be), 64'hF0);
        chk("SW64 bus_wdata", bwd, 64'hCAFEF00D00000000);

        // Reset in RESP abandons the access
        we = 1'b0; size = 3'b011; addr = 64'h10; req64 = 1'b1;
        @(negedge clk);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        chk("RESP bus_req", 64'(c_breq), 64'd0);
        rst64 = 1'b1;
        @(negedge clk);
        rst64 = 1'b0; req64 = 1'b0;
        #1;
        chk("mid reset doneM", 64'(c_done), 64'd0);
        chk("mid reset stallM", 64'(c_stall), 64'd0);
        chk("mid reset readdataM", c_rd, 64'd0);
        rvalid = 1'b1; rdata = 64'h5555AAAA5555AAAA;
        @(negedge clk);
        rvalid = 1'b0;
        chk("late rvalid doneM", 64'(c_done), 64'd0);
        chk("late rvalid readdataM", c_rd, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
